// File: rtl/bus_regs_pkg.sv
// Shared constants for the six-register bus slice: register indices, count, idle select code.
// Pure declarations; no logic, no latency, no flow control.
package bus_regs_pkg;

  localparam int NUM_REGS = 6;

  localparam int IDX_AR = 0;
  localparam int IDX_PC = 1;
  localparam int IDX_DR = 2;
  localparam int IDX_AC = 3;
  localparam int IDX_IR = 4;
  localparam int IDX_TR = 5;

  // Select code that points the downstream mux at its constant-zero input.
  localparam logic [2:0] SEL_NONE = 3'b111;

endpackage

// File: rtl/bus_regs_reg.sv
// One WIDTH-bit bus register with clear > load > increment priority and async reset.
// Latency: one clock from enable to output; no backpressure, every enable is taken.
module bus_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic             inr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (ld)
      q <= d;
    else if (inr)
      q <= q + 1'b1;
  end

endmodule

// File: rtl/bus_regs.sv
// Six bus-attached registers (AR,PC,DR,AC,IR,TR), rd-to-select encoder and sticky rd error.
// Latency: registers one clock, select zero (combinational); no backpressure.
module bus_regs
  import bus_regs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [WIDTH-1:0] alu_in,
  input  logic             ac_ld_alu,
  input  logic [5:0]       ld,
  input  logic [5:0]       inr,
  input  logic [5:0]       clr,
  input  logic [5:0]       rd,
  output logic [WIDTH-1:0] ar,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] dr,
  output logic [WIDTH-1:0] ac,
  output logic [WIDTH-1:0] ir,
  output logic [WIDTH-1:0] tr,
  output logic             s0,
  output logic             s1,
  output logic             s2,
  output logic             rd_err
);

  logic [WIDTH-1:0] q [NUM_REGS];
  logic [2:0]       sel;
  logic             rd_multi;

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_reg
      if (g == IDX_AC) begin : g_ac
        // ALU result outranks the bus; clr still wins inside bus_reg.
        logic [WIDTH-1:0] d_ac;
        assign d_ac = ac_ld_alu ? alu_in : bus_in;
        bus_reg #(.WIDTH(WIDTH)) u_reg (
          .clk (clk),
          .rst (rst),
          .clr (clr[g]),
          .ld  (ld[g] | ac_ld_alu),
          .inr (inr[g]),
          .d   (d_ac),
          .q   (q[g])
        );
      end else begin : g_std
        bus_reg #(.WIDTH(WIDTH)) u_reg (
          .clk (clk),
          .rst (rst),
          .clr (clr[g]),
          .ld  (ld[g]),
          .inr (inr[g]),
          .d   (bus_in),
          .q   (q[g])
        );
      end
    end
  endgenerate

  assign ar = q[IDX_AR];
  assign pc = q[IDX_PC];
  assign dr = q[IDX_DR];
  assign ac = q[IDX_AC];
  assign ir = q[IDX_IR];
  assign tr = q[IDX_TR];

  // Scan high to low so the lowest set rd bit is the last writer.
  always_comb begin
    sel = SEL_NONE;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (rd[i])
        sel = 3'(i);
    end
  end

  assign {s2, s1, s0} = sel;

  assign rd_multi = |(rd & (rd - 6'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_err <= 1'b0;
    else if (rd_multi)
      rd_err <= 1'b1;
  end

endmodule

// File: tb/tb_bus_regs.sv
// Randomized + directed bench for bus_regs against an array-based reference model.
module tb_bus_regs;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] bus_in, alu_in;
  logic         ac_ld_alu;
  logic [5:0]   ld, inr, clr, rd;
  logic [W-1:0] ar, pc, dr, ac, ir, tr;
  logic         s0, s1, s2, rd_err;

  int tests = 0;
  int fails = 0;
  int mreg[6];
  bit merr;

  bus_regs #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .alu_in(alu_in), .ac_ld_alu(ac_ld_alu),
    .ld(ld), .inr(inr), .clr(clr), .rd(rd),
    .ar(ar), .pc(pc), .dr(dr), .ac(ac), .ir(ir), .tr(tr),
    .s0(s0), .s1(s1), .s2(s2), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int exp_sel(input logic [5:0] r);
    for (int i = 0; i < 6; i++)
      if (r[i]) return i;
    return 7;
  endfunction

  function automatic int popc(input logic [5:0] r);
    int n = 0;
    for (int i = 0; i < 6; i++) n += int'(r[i]);
    return n;
  endfunction

  function automatic logic [W-1:0] dut_reg(input int i);
    case (i)
      0: return ar;
      1: return pc;
      2: return dr;
      3: return ac;
      4: return ir;
      default: return tr;
    endcase
  endfunction

  // Value the downstream mux would put on the bus for a given rd.
  function automatic logic [W-1:0] mux_bus(input logic [5:0] r);
    int s = exp_sel(r);
    return (s == 7) ? '0 : W'(mreg[s]);
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s_reg%0d", tag, i), 32'(dut_reg(i)), 32'(mreg[i]));
    chk({tag, "_rd_err"}, 32'(rd_err), 32'(merr));
  endtask

  // Called at posedge+1; drives one cycle, checks select before and registers after the edge.
  task automatic cycle(input string tag, input logic [5:0] l, input logic [5:0] n,
                       input logic [5:0] c, input logic [5:0] r, input logic a,
                       input logic [W-1:0] alu, input logic [W-1:0] b);
    ld = l; inr = n; clr = c; rd = r; ac_ld_alu = a; alu_in = alu; bus_in = b;
    #1;
    chk({tag, "_sel"}, 32'({s2, s1, s0}), 32'(exp_sel(r)));
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      if (c[i])              mreg[i] = 0;
      else if (i == 3 && a)  mreg[i] = int'(alu);
      else if (l[i])         mreg[i] = int'(b);
      else if (n[i])         mreg[i] = (mreg[i] + 1) % (1 << W);
    end
    if (popc(r) > 1) merr = 1'b1;
    #1;
    check_regs(tag);
  endtask

  initial begin
    logic [5:0] rl, rn, rc, rr;
    int k;
    rst = 1'b1; ld = '0; inr = '0; clr = '0; rd = '0; ac_ld_alu = 1'b0;
    alu_in = '0; bus_in = '0;
    for (int i = 0; i < 6; i++) mreg[i] = 0;
    merr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");
    chk("reset_sel_idle", 32'({s2, s1, s0}), 32'h7);
    rst = 1'b0;

    // Transfer PC -> AR over the bus
    cycle("ld_pc", 6'b000010, '0, '0, '0, 1'b0, '0, 8'h3C);
    chk("pc_3c", 32'(pc), 32'h3C);
    cycle("xfer", 6'b000001, '0, '0, 6'b000010, 1'b0, '0, mux_bus(6'b000010));
    chk("xfer_sel", 32'({s2, s1, s0}), 32'h1);
    chk("xfer_ar", 32'(ar), 32'h3C);

    // Self reload is harmless
    cycle("self", 6'b000010, '0, '0, 6'b000010, 1'b0, '0, mux_bus(6'b000010));
    chk("self_pc", 32'(pc), 32'h3C);

    // Priority clr > ld > inr
    cycle("pc10", 6'b000010, '0, '0, '0, 1'b0, '0, 8'h10);
    cycle("prio_all", 6'b000010, 6'b000010, 6'b000010, '0, 1'b0, '0, 8'h77);
    chk("prio_clr", 32'(pc), 32'h0);
    cycle("prio_ldinr", 6'b000010, 6'b000010, '0, '0, 1'b0, '0, 8'h55);
    chk("prio_ld", 32'(pc), 32'h55);

    // Wrap
    cycle("tr_ff", 6'b100000, '0, '0, '0, 1'b0, '0, 8'hFF);
    cycle("tr_wrap", '0, 6'b100000, '0, '0, 1'b0, '0, 8'h00);
    chk("wrap_tr", 32'(tr), 32'h0);

    // AC source selection
    cycle("ac_alu", 6'b001000, '0, '0, '0, 1'b1, 8'hA5, 8'h11);
    chk("ac_a5", 32'(ac), 32'hA5);
    cycle("ac_clr", 6'b001000, '0, 6'b001000, '0, 1'b1, 8'hA5, 8'h11);
    chk("ac_clr0", 32'(ac), 32'h0);

    // Select error and idle select
    cycle("multi", '0, '0, '0, 6'b001100, 1'b0, '0, mux_bus(6'b001100));
    chk("multi_sel", 32'({s2, s1, s0}), 32'h2);
    chk("rd_err_set", 32'(rd_err), 32'h1);
    cycle("after_multi", '0, '0, '0, 6'b000001, 1'b0, '0, mux_bus(6'b000001));
    chk("rd_err_sticky", 32'(rd_err), 32'h1);
    cycle("idle", '0, '0, '0, 6'b000000, 1'b0, '0, '0);
    chk("idle_sel", 32'({s2, s1, s0}), 32'h7);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      rl = 6'($urandom) & 6'($urandom);
      rn = 6'($urandom) & 6'($urandom);
      rc = 6'($urandom) & 6'($urandom) & 6'($urandom);
      k  = int'($urandom_range(0, 9));
      if (k < 6)       rr = 6'(1 << k);
      else if (k == 6) rr = '0;
      else             rr = 6'($urandom);
      cycle("rnd", rl, rn, rc, rr, 1'($urandom_range(0, 3) == 0), W'($urandom),
            ($urandom_range(0, 1) == 0) ? mux_bus(rr) : W'($urandom));
    end

    // Load everything, then async reset mid-cycle while enables are active
    cycle("preload", 6'b111111, '0, '0, '0, 1'b0, '0, 8'h5A);
    cycle("mkerr", '0, '0, '0, 6'b110000, 1'b0, '0, '0);
    #2;
    rst = 1'b1;
    ld = 6'b111111; inr = 6'b111111; clr = '0; rd = 6'b000100; bus_in = 8'hAA;
    ac_ld_alu = 1'b1; alu_in = 8'hC3;
    for (int i = 0; i < 6; i++) mreg[i] = 0;
    merr = 1'b0;
    #1;
    check_regs("async_rst");
    chk("rst_sel", 32'({s2, s1, s0}), 32'h2);
    @(posedge clk);
    #1;
    check_regs("rst_hold");
    rst = 1'b0;
    cycle("post_rst", 6'b000100, 6'b000001, '0, '0, 1'b0, '0, 8'h21);
    chk("post_rst_dr", 32'(dr), 32'h21);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_regs.md
BUS_REGS -- requirements
Module: bus_regs

Interface
REQ-001 Parameter: WIDTH, default 8, data width of every register and of the bus.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: bus_in  input  WIDTH  common bus value, driven by the downstream bus multiplexer output.
REQ-005 Port: alu_in  input  WIDTH  ALU result, loadable into AC only.
REQ-006 Port: ac_ld_alu  input  1  load AC from alu_in.
REQ-007 Port: ld  input  6  per-register load-from-bus enables.
REQ-008 Port: inr  input  6  per-register increment enables.
REQ-009 Port: clr  input  6  per-register clear enables.
REQ-010 Port: rd  input  6  one-hot request naming which register drives the bus.
REQ-011 Port: ar, pc, dr, ac, ir, tr  output  WIDTH each  register contents, wired to bus sources a..f.
REQ-012 Port: s0, s1, s2  output  1 each  bus select, with {s2,s1,s0} = source index.
REQ-013 Port: rd_err  output  1  sticky flag for a non-one-hot rd.

Function
REQ-014 Index map (bit i of ld/inr/clr/rd, select code i): 0=AR, 1=PC, 2=DR, 3=AC, 4=IR, 5=TR.
REQ-015 Per register, per edge, priority: clr (value 0) > ld (value bus_in) > inr (value +1) > hold.
REQ-016 AC only: ac_ld_alu ranks between clr[3] and ld[3]; alu_in beats bus_in.
REQ-017 Increment is modulo 2^WIDTH: 8'hFF + 1 = 8'h00, with no carry output.
REQ-018 Each register updates independently; any combination of registers may change on the same edge.
REQ-019 Select encoding is combinational from rd, with zero latency:
- exactly one rd bit i set: {s2,s1,s0} = i;
- rd = 0: {s2,s1,s0} = 3'b111, so the bus reads 0;
- more than one bit set: the lowest set index wins.
REQ-020 rd_err is set on the edge after any cycle where popcount(rd) > 1.
REQ-021 rd_err stays at 1 until rst.
REQ-022 A register loading its own value from the bus (rd[i] and ld[i]) reloads its current value with no glitch; this is legal.
REQ-023 Register-to-register transfer latency is one clock: the destination shows the source value the edge after ld asserts.
REQ-024 Outputs ar..tr are register outputs, never combinational from inputs.

Reset
REQ-025 rst asserted forces all six registers and rd_err to 0 immediately, without waiting for clk.
REQ-026 s0, s1 and s2 follow rd combinationally and are unaffected by rst.
REQ-027 Any ld, inr or clr during rst is ignored.
REQ-028 The first update takes effect on the first rising clk edge after rst deasserts.
REQ-029 rst asserted mid-transfer discards that transfer.

Structure
REQ-030 The shared package shall hold:
- register index constants (IDX_AR..IDX_TR);
- NUM_REGS = 6;
- SEL_NONE = 3'b111.
REQ-031 Sub-module bus_reg (one WIDTH-bit register with clr/ld/inr and async rst) shall be instantiated six times.
REQ-032 The AC instance shall use a 2:1 data pre-select (alu_in vs bus_in) ahead of bus_reg.
REQ-033 The rd-to-select priority encoder and rd_err logic shall live in bus_regs.

Verification
REQ-034 Reset: assert rst mid-cycle with all registers loaded -> all outputs read 0 before the next clk; rd_err = 0.
REQ-035 Transfer: load PC from bus_in = 8'h3C, then rd = 6'b000010 and ld[0] = 1 ->
- the same cycle, {s2,s1,s0} = 3'b001;
- the next edge, ar = 8'h3C.
REQ-036 Priority: on PC = 8'h10, apply ld[1], inr[1] and clr[1] together -> PC = 0.
- Next, apply ld[1] and inr[1] with bus_in = 8'h55 -> PC = 8'h55.
REQ-037 Wrap: TR = 8'hFF, inr[5] -> TR = 8'h00.
REQ-038 AC source: ac_ld_alu = 1, alu_in = 8'hA5, ld[3] = 1, bus_in = 8'h11 -> AC = 8'hA5.
- With clr[3] also set -> AC = 0.
REQ-039 Select error: rd = 6'b001100 -> {s2,s1,s0} = 3'b010.
- rd_err rises on the next edge and stays at 1 after rd returns to 6'b000001.
- rd = 0 -> select 3'b111.
